pulse_stretcher: RTL and testbench



---
 rtl/pulse_stretcher_pkg.sv | 34 +++
 rtl/pulse_stretcher_if.sv | 37 +++
 rtl/pulse_stretcher_sat_counter.sv | 69 ++++++
 rtl/pulse_stretcher.sv | 131 +++++++++++++
 tb/tb_pulse_stretcher.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pulse_stretcher_pkg.sv
// -----------------------------------------------------------------------------
// pulse_stretcher_pkg
// Shared definitions for the pulse stretcher: the FSM state encoding and a
// parameter-legality helper evaluated at elaboration time by the top level.
// -----------------------------------------------------------------------------
package pulse_stretcher_pkg;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] ON_ENC   = 2'd1;
  localparam logic [1:0] GAP_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE_ENC,
    ST_ON   = ON_ENC,
    ST_GAP  = GAP_ENC
  } state_e;

  // Both phases must last at least one cycle, and the phase timer must be
  // wide enough to represent the longer of the two phase lengths.
  function automatic bit params_legal(int on_cycles, int off_cycles, int k);
    longint unsigned longest;
    bit              ok;
    longest = (on_cycles > off_cycles) ? longint'(on_cycles) : longint'(off_cycles);
    ok = (on_cycles >= 32'sd1) && (off_cycles >= 32'sd1) &&
         (k >= 32'sd1) && (k <= 32'sd62);
    if (ok) begin
      ok = (longest < (64'd1 << k));
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// -----------------------------------------------------------------------------
// pulse_stretcher_if
// Event/status bundle of the pulse stretcher.
//   trig     : event strobe, one event per cycle sampled high (master -> slave)
//   out      : stretched pulse output                         (slave -> master)
//   busy     : stretcher is not idle                          (slave -> master)
//   pending  : events queued and not yet started              (slave -> master)
//   overflow : one-cycle pulse, an event was dropped          (slave -> master)
// The slave modport is the stretcher itself; the master is the event source.
// -----------------------------------------------------------------------------
interface pulse_stretcher_if #(
  parameter int QW = 4
);

  logic          trig;
  logic          out;
  logic          busy;
  logic [QW-1:0] pending;
  logic          overflow;

  modport master (
    output trig,
    input  out,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  trig,
    output out,
    output busy,
    output pending,
    output overflow
  );

endinterface

// File: rtl/pulse_stretcher_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit saturating up/down counter used as the pending-event queue depth.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_i      : request +1
//   dec_i      : request -1 (held at zero when already empty)
//   count_o    : current count, registered
//   drop_o     : one-cycle pulse, an increment was refused at full scale
// inc_i and dec_i together leave the count unchanged and never drop, even at
// full scale, because the incoming event takes the slot being released.
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         drop_o
);

  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = W'(32'd1);

  logic [W-1:0] count_q, count_d;
  logic         drop_q, drop_d;

  // Next count and drop flag from the inc/dec request pair.
  always_comb begin
    count_d = count_q;
    drop_d  = 1'b0;
    case ({inc_i, dec_i})
      2'b10: begin
        if (count_q == CNT_MAX) begin
          drop_d = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      2'b01: begin
        if (count_q != CNT_ZERO) begin
          count_d = count_q - CNT_ONE;
        end else begin
          count_d = CNT_ZERO;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Count and drop registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= CNT_ZERO;
      drop_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign count_o = count_q;
  assign drop_o  = drop_q;

endmodule

// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
// Turns single-cycle event strobes into fixed-length output pulses separated by
// a guaranteed low gap. Events arriving while a pulse or gap is in progress are
// queued in a saturating counter and replayed one per pulse.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any pulse and
//                discards queued events)
//   ps         : slave side of pulse_stretcher_if (trig in; out, busy,
//                pending, overflow out, all registered)
// -----------------------------------------------------------------------------
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int ON_CYCLES  = 3,
  parameter int OFF_CYCLES = 3,
  parameter int K          = 32,
  parameter int QW         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pulse_stretcher_if.slave   ps
);

  if (!params_legal(ON_CYCLES, OFF_CYCLES, K)) begin : g_bad_params
    $error("pulse_stretcher: illegal ON_CYCLES/OFF_CYCLES/K combination");
  end

  localparam logic [K-1:0] TIMER_ZERO = {K{1'b0}};
  localparam logic [K-1:0] TIMER_ONE  = K'(32'd1);
  localparam logic [K-1:0] ON_LAST    = K'(ON_CYCLES - 1);
  localparam logic [K-1:0] OFF_LAST   = K'(OFF_CYCLES - 1);

  state_e        state_q, state_d;
  logic [K-1:0]  timer_q, timer_d;
  logic          out_q, out_d;
  logic          busy_q, busy_d;

  logic          inc_s;
  logic          dec_s;
  logic [QW-1:0] pending_s;
  logic          drop_s;
  logic          have_pending_s;

  assign have_pending_s = (pending_s != {QW{1'b0}});

  // Phase sequencing: IDLE -> ON -> GAP, and at the end of GAP either replay a
  // queued event, start straight on a fresh trig, or fall back to IDLE. A trig
  // seen in ON or GAP is queued, except the one that starts the next pulse
  // from an empty queue on the last GAP cycle.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    inc_s   = 1'b0;
    dec_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = TIMER_ZERO;
        if (ps.trig) begin
          state_d = ST_ON;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ON: begin
        inc_s = ps.trig;
        if (timer_q == ON_LAST) begin
          state_d = ST_GAP;
          timer_d = TIMER_ZERO;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      ST_GAP: begin
        if (timer_q == OFF_LAST) begin
          timer_d = TIMER_ZERO;
          if (have_pending_s) begin
            // Oldest queued event starts now; a simultaneous trig takes its slot.
            state_d = ST_ON;
            dec_s   = 1'b1;
            inc_s   = ps.trig;
          end else if (ps.trig) begin
            state_d = ST_ON;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
          inc_s   = ps.trig;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = TIMER_ZERO;
      end
    endcase
    out_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

  // State, phase timer and decoded outputs, registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= TIMER_ZERO;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  sat_counter #(
    .W (QW)
  ) u_pending (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (inc_s),
    .dec_i   (dec_s),
    .count_o (pending_s),
    .drop_o  (drop_s)
  );

  assign ps.out      = out_q;
  assign ps.busy     = busy_q;
  assign ps.pending  = pending_s;
  assign ps.overflow = drop_s;

endmodule

// File: tb/tb_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretcher
// Two instances share one trig: dut_a (ON=3, OFF=2, QW=2) and dut_b
// (ON=1, OFF=1, QW=2). Directed vectors are 24-cycle bit masks where bit i is
// cycle 10+i; randomized traffic is compared against a pulse-schedule model
// that tracks only the start cycle of the current pulse and the queue depth.
// -----------------------------------------------------------------------------
module tb_pulse_stretcher;

  localparam int QW   = 2;
  localparam int PMAX = (1 << QW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig = 1'b0;

  always #5 clk = ~clk;

  pulse_stretcher_if #(.QW(QW)) ifa ();
  pulse_stretcher_if #(.QW(QW)) ifb ();

  assign ifa.trig = trig;
  assign ifb.trig = trig;

  pulse_stretcher #(.ON_CYCLES(3), .OFF_CYCLES(2), .K(8), .QW(QW)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ps    (ifa.slave)
  );

  pulse_stretcher #(.ON_CYCLES(1), .OFF_CYCLES(1), .K(8), .QW(QW)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ps    (ifb.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: pulse start cycle + queue depth --------
  int on_c[2]  = '{3, 1};
  int off_c[2] = '{2, 1};
  int m_s[2];
  int m_p[2];
  bit m_ovf[2];
  int n;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_s[d]   = -1000;
      m_p[d]   = 0;
      m_ovf[d] = 1'b0;
    end
    n = 0;
  endtask

  // Advance model d past cycle n given the trig sampled during cycle n.
  task automatic model_step(input int d, input bit t);
    int last;
    bit ovf_n;
    last  = m_s[d] + on_c[d] + off_c[d] - 1;
    ovf_n = 1'b0;
    if (n > last) begin
      if (t) m_s[d] = n + 1;
    end else if (n == last) begin
      if (m_p[d] > 0) begin
        m_s[d] = n + 1;
        if (!t) m_p[d] = m_p[d] - 1;
      end else if (t) begin
        m_s[d] = n + 1;
      end
    end else if (t) begin
      if (m_p[d] == PMAX) ovf_n = 1'b1;
      else m_p[d] = m_p[d] + 1;
    end
    m_ovf[d] = ovf_n;
  endtask

  task automatic chk_model(input int d, input logic o, input logic b,
                           input logic [QW-1:0] p, input logic v);
    bit eo, eb;
    eo = (n >= m_s[d]) && (n < m_s[d] + on_c[d]);
    eb = (n >= m_s[d]) && (n < m_s[d] + on_c[d] + off_c[d]);
    chk($sformatf("rand%0d.out c%0d", d, n), {31'd0, o}, {31'd0, eo});
    chk($sformatf("rand%0d.busy c%0d", d, n), {31'd0, b}, {31'd0, eb});
    chk($sformatf("rand%0d.pending c%0d", d, n), {30'd0, p}, m_p[d]);
    chk($sformatf("rand%0d.overflow c%0d", d, n), {31'd0, v}, {31'd0, m_ovf[d]});
  endtask

  // Reset both instances, checking the reset state while rst_n is low; ends
  // at a negedge so that the next negedge is "cycle 10" of a directed test.
  task automatic do_reset();
    @(negedge clk);
    trig  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset.a.out", {31'd0, ifa.out}, 32'd0);
    chk("reset.a.busy", {31'd0, ifa.busy}, 32'd0);
    chk("reset.a.pending", {30'd0, ifa.pending}, 32'd0);
    chk("reset.a.overflow", {31'd0, ifa.overflow}, 32'd0);
    chk("reset.b.busy", {31'd0, ifb.busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
  endtask

  typedef struct {
    string       name;
    bit          use_b;
    logic [23:0] trig;
    logic [23:0] out;
    logic [23:0] busy;
    logic [23:0] ovf;
    logic [23:0] phi;
    logic [23:0] plo;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[5];
    int   biases[6];
    logic o, b, v;
    logic [QW-1:0] p;
    bit   t;

    vecs[0] = '{"single",   1'b0, 24'h000001, 24'h00000E, 24'h00003E, 24'h000000, 24'h000000, 24'h000000};
    vecs[1] = '{"queue2",   1'b0, 24'h000007, 24'h0039CE, 24'h00FFFE, 24'h000000, 24'h000038, 24'h0007C4};
    vecs[2] = '{"saturate", 1'b0, 24'h00001F, 24'h0739CE, 24'h1FFFFE, 24'h000020, 24'h0007F8, 24'h00F834};
    vecs[3] = '{"lastgap",  1'b0, 24'h000021, 24'h0001CE, 24'h0007FE, 24'h000000, 24'h000000, 24'h000000};
    vecs[4] = '{"fast",     1'b1, 24'h00000F, 24'h0000AA, 24'h0001FE, 24'h000000, 24'h000010, 24'h00006C};
    biases  = '{5, 30, 60, 90, 100, 15};

    model_reset();

    // ---------------- table-driven directed tests ----------------
    for (int k = 0; k < 5; k++) begin
      do_reset();
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        o = vecs[k].use_b ? ifb.out      : ifa.out;
        b = vecs[k].use_b ? ifb.busy     : ifa.busy;
        p = vecs[k].use_b ? ifb.pending  : ifa.pending;
        v = vecs[k].use_b ? ifb.overflow : ifa.overflow;
        chk($sformatf("%s.out c%0d", vecs[k].name, 10 + i), {31'd0, o}, {31'd0, vecs[k].out[i]});
        chk($sformatf("%s.busy c%0d", vecs[k].name, 10 + i), {31'd0, b}, {31'd0, vecs[k].busy[i]});
        chk($sformatf("%s.pending c%0d", vecs[k].name, 10 + i), {30'd0, p},
            {30'd0, vecs[k].phi[i], vecs[k].plo[i]});
        chk($sformatf("%s.overflow c%0d", vecs[k].name, 10 + i), {31'd0, v}, {31'd0, vecs[k].ovf[i]});
        trig = vecs[k].trig[i];
      end
      trig = 1'b0;
    end

    // ---------------- asynchronous reset mid-pulse ----------------
    do_reset();
    @(negedge clk);                       // cycle 10
    trig = 1'b1;
    @(negedge clk);                       // cycle 11
    chk("areset.out c11", {31'd0, ifa.out}, 32'd1);
    trig = 1'b1;
    @(negedge clk);                       // cycle 12
    chk("areset.pending c12", {30'd0, ifa.pending}, 32'd1);
    trig = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("areset.out async", {31'd0, ifa.out}, 32'd0);
    chk("areset.busy async", {31'd0, ifa.busy}, 32'd0);
    chk("areset.pending async", {30'd0, ifa.pending}, 32'd0);
    @(negedge clk);                       // cycle 13
    @(negedge clk);                       // cycle 14
    rst_n = 1'b1;
    for (int c = 15; c <= 30; c++) begin
      @(negedge clk);
      chk($sformatf("areset.out c%0d", c), {31'd0, ifa.out}, {31'd0, (c >= 21 && c <= 23)});
      chk($sformatf("areset.pending c%0d", c), {30'd0, ifa.pending}, 32'd0);
      trig = (c == 20);
    end
    trig = 1'b0;

    // ---------------- randomized traffic vs. model ----------------
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      chk_model(0, ifa.out, ifa.busy, ifa.pending, ifa.overflow);
      chk_model(1, ifb.out, ifb.busy, ifb.pending, ifb.overflow);
      t = ($urandom_range(99, 0) < biases[k / 500]);
      model_step(0, t);
      model_step(1, t);
      trig = t;
      n++;
    end
    trig = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
